fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the vectorial ASIP pipeline.
- Owns the PC and drives the instruction-memory request/acknowledge handshake.
- Directly consumes the hazard unit's StallF, StallD and FlushD outputs, and the Execute-stage branch redirect.
- Produces InstrD, PCD and ValidD for the Decode stage, whose register addresses (RA1D/RA2D) feed back into the hazard unit.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/if_id_reg.sv | 44 ++++
 rtl/fetch_stage.sv | 138 +++++++++++++
 tb/tb_fetch_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the vectorial ASIP pipeline: fetch FSM states,
// default datapath widths and the encoding used for a pipeline bubble.
package cpu_pkg;

    localparam int PC_W_DEFAULT    = 32;
    localparam int INSTR_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [INSTR_W_DEFAULT-1:0] BUBBLE_INSTR = '0;

endpackage : cpu_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: reset > flush > stall > load, where a
// flush always leaves a bubble (valid low, bubble instruction word).
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               stall_i,
    input  logic               valid_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            instr_q <= INSTR_W'(BUBBLE_INSTR);
        end else if (!stall_i) begin
            valid_q <= valid_i;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ack handshake,
// parks an acked-but-stalled instruction in a skid buffer and feeds IF/ID.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter int              INSTR_W  = INSTR_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               BranchTakenE,
    input  logic [PC_W-1:0]    BranchTargetE,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic [PC_W-1:0]    PCF,
    output logic [INSTR_W-1:0] InstrD,
    output logic [PC_W-1:0]    PCD,
    output logic               ValidD,
    output logic               FetchWaitF
);

    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pc_inc;

    logic               skid_vld_q, skid_vld_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;

    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic [PC_W-1:0]    id_pc;

    assign pc_inc = pc_q + PC_W'(PC_STEP);

    // When IF/ID is not stalled and nothing is delivered, the default entry
    // below is a bubble, so a missing ack shows up as ValidD=0 next cycle.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_vld_d   = skid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        imem_req     = 1'b0;
        FetchWaitF   = 1'b0;
        id_valid     = 1'b0;
        id_instr     = INSTR_W'(BUBBLE_INSTR);
        id_pc        = pc_q;

        unique case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (!StallF) begin
                        id_valid = 1'b1;
                        id_instr = imem_rdata;
                        id_pc    = pc_q;
                        pc_d     = pc_inc;
                    end else begin
                        skid_vld_d   = 1'b1;
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        state_d      = S_HOLD;
                    end
                end else begin
                    FetchWaitF = 1'b1;
                end
            end
            S_HOLD: begin
                if (!StallF) begin
                    id_valid   = skid_vld_q;
                    id_instr   = skid_instr_q;
                    id_pc      = skid_pc_q;
                    skid_vld_d = 1'b0;
                    pc_d       = pc_inc;
                    state_d    = S_FETCH;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        // A redirect beats stalls, drops the skid entry and any same-cycle ack.
        if (BranchTakenE) begin
            pc_d       = BranchTargetE;
            skid_vld_d = 1'b0;
            state_d    = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            skid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
    end

    assign imem_addr = pc_q;
    assign PCF       = pc_q;

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .flush_i (FlushD | BranchTakenE),
        .stall_i (StallD),
        .valid_i (id_valid),
        .instr_i (id_instr),
        .pc_i    (id_pc),
        .valid_o (ValidD),
        .instr_o (InstrD),
        .pc_o    (PCD)
    );

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle-by-cycle vector table plus short
// hand-written sequences for redirect-vs-ack and wait-under-StallD cases.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD, BranchTakenE;
    logic [31:0] BranchTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] PCF, InstrD, PCD;
    logic        ValidD, FetchWaitF;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Memory model: zero-wait, instruction word derived from the address.
    assign imem_rdata = imem_addr ^ 32'h5A00_0000;

    fetch_stage #(
        .PC_W     (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .StallF        (StallF),
        .StallD        (StallD),
        .FlushD        (FlushD),
        .BranchTakenE  (BranchTakenE),
        .BranchTargetE (BranchTargetE),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .PCF           (PCF),
        .InstrD        (InstrD),
        .PCD           (PCD),
        .ValidD        (ValidD),
        .FetchWaitF    (FetchWaitF)
    );

    typedef struct {
        logic        rst, sf, sd, fl, br;
        logic [31:0] tgt;
        logic        ack;
        logic        req;
        logic [31:0] addr;
        logic        wt, vd;
        logic [31:0] id, pcd;
        logic        cp;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    function automatic vec_t v(logic rst, logic sf, logic sd, logic fl, logic br,
                               logic [31:0] tgt, logic ack, logic req, logic [31:0] addr,
                               logic wt, logic vd, logic [31:0] id, logic [31:0] pcd,
                               logic cp);
        vec_t r;
        r.rst = rst; r.sf = sf; r.sd = sd; r.fl = fl; r.br = br; r.tgt = tgt;
        r.ack = ack; r.req = req; r.addr = addr; r.wt = wt; r.vd = vd;
        r.id = id; r.pcd = pcd; r.cp = cp;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic drive(input logic rst, input logic sf, input logic sd, input logic fl,
                         input logic br, input logic [31:0] tgt, input logic ack);
        reset = rst; StallF = sf; StallD = sd; FlushD = fl;
        BranchTakenE = br; BranchTargetE = tgt; imem_ack = ack;
    endtask

    initial begin
        // rst sf sd fl br tgt ack | req addr wt vd InstrD PCD chkPCD
        vecs[0]  = v(1,0,0,0,0,32'h0,0,        0,32'h00,0,0,32'h0,32'h0,1);
        vecs[1]  = v(0,0,0,0,0,32'h0,1,        0,32'h00,0,0,32'h0,32'h0,1);
        vecs[2]  = v(0,0,0,0,0,32'h0,1,        1,32'h00,0,0,32'h0,32'h0,1);
        vecs[3]  = v(0,0,0,0,0,32'h0,1,        1,32'h04,0,1,32'h5A000000,32'h0,1);
        vecs[4]  = v(0,1,1,0,0,32'h0,1,        1,32'h08,0,1,32'h5A000004,32'h4,1);
        vecs[5]  = v(0,1,1,0,0,32'h0,1,        0,32'h08,0,1,32'h5A000004,32'h4,1);
        vecs[6]  = v(0,0,0,0,0,32'h0,1,        0,32'h08,0,1,32'h5A000004,32'h4,1);
        vecs[7]  = v(0,0,0,0,0,32'h0,1,        1,32'h0C,0,1,32'h5A000008,32'h8,1);
        vecs[8]  = v(0,0,0,0,0,32'h0,0,        1,32'h10,1,1,32'h5A00000C,32'hC,1);
        vecs[9]  = v(0,0,0,0,0,32'h0,0,        1,32'h10,1,0,32'h0,32'h0,0);
        vecs[10] = v(0,0,0,0,0,32'h0,0,        1,32'h10,1,0,32'h0,32'h0,0);
        vecs[11] = v(0,0,0,0,0,32'h0,1,        1,32'h10,0,0,32'h0,32'h0,0);
        vecs[12] = v(0,1,1,0,0,32'h0,1,        1,32'h14,0,1,32'h5A000010,32'h10,1);
        vecs[13] = v(0,1,1,0,1,32'h40,0,       0,32'h14,0,1,32'h5A000010,32'h10,1);
        vecs[14] = v(0,0,0,0,0,32'h0,1,        1,32'h40,0,0,32'h0,32'h0,0);
        vecs[15] = v(0,0,1,1,0,32'h0,0,        1,32'h44,1,1,32'h5A000040,32'h40,1);
        vecs[16] = v(0,0,0,0,0,32'h0,1,        1,32'h44,0,0,32'h0,32'h0,0);
        vecs[17] = v(0,0,0,0,1,32'hFFFFFFFC,1, 1,32'h48,0,1,32'h5A000044,32'h44,1);
        vecs[18] = v(0,0,0,0,0,32'h0,1,        1,32'hFFFFFFFC,0,0,32'h0,32'h0,0);
        vecs[19] = v(0,0,0,0,0,32'h0,1,        1,32'h00,0,1,32'hA5FFFFFC,32'hFFFFFFFC,1);
        vecs[20] = v(0,1,1,0,0,32'h0,1,        1,32'h04,0,1,32'h5A000000,32'h0,1);
        vecs[21] = v(1,1,1,0,0,32'h0,0,        0,32'h04,0,1,32'h5A000000,32'h0,1);
        vecs[22] = v(0,0,0,0,0,32'h0,1,        0,32'h00,0,0,32'h0,32'h0,1);
        vecs[23] = v(0,0,0,0,0,32'h0,1,        1,32'h00,0,0,32'h0,32'h0,1);
        vecs[24] = v(0,0,0,0,0,32'h0,1,        1,32'h04,0,1,32'h5A000000,32'h0,1);

        drive(1, 0, 0, 0, 0, 32'h0, 0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].sf, vecs[i].sd, vecs[i].fl, vecs[i].br,
                  vecs[i].tgt, vecs[i].ack);
            #1;
            chk("imem_req",   i, {31'b0, imem_req},   {31'b0, vecs[i].req});
            chk("imem_addr",  i, imem_addr,           vecs[i].addr);
            chk("PCF",        i, PCF,                 vecs[i].addr);
            chk("FetchWaitF", i, {31'b0, FetchWaitF}, {31'b0, vecs[i].wt});
            chk("ValidD",     i, {31'b0, ValidD},     {31'b0, vecs[i].vd});
            chk("InstrD",     i, InstrD,              vecs[i].id);
            if (vecs[i].cp) chk("PCD", i, PCD, vecs[i].pcd);
        end

        // Redirect with a same-cycle ack under StallF: ack dropped, no HOLD entered.
        @(negedge clk);
        drive(0, 1, 1, 0, 1, 32'h80, 1);
        #1;
        chk("redir_req",  100, {31'b0, imem_req}, 32'h1);
        chk("redir_addr", 100, imem_addr, 32'h8);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h0, 1);
        #1;
        chk("redir_req2",  101, {31'b0, imem_req}, 32'h1);
        chk("redir_pcf",   101, PCF, 32'h80);
        chk("redir_valid", 101, {31'b0, ValidD}, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        #1;
        chk("tgt_valid", 102, {31'b0, ValidD}, 32'h1);
        chk("tgt_instr", 102, InstrD, 32'h5A000080);
        chk("tgt_pcd",   102, PCD, 32'h80);
        chk("tgt_wait",  102, {31'b0, FetchWaitF}, 32'h1);

        // Missing ack while StallD holds IF/ID: no bubble replaces the instruction.
        StallD = 1'b1;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h0, 1);
        #1;
        chk("hold_valid", 103, {31'b0, ValidD}, 32'h1);
        chk("hold_instr", 103, InstrD, 32'h5A000080);
        chk("hold_addr",  103, imem_addr, 32'h84);
        @(negedge clk);
        #1;
        chk("resume_instr", 104, InstrD, 32'h5A000084);
        chk("resume_pcd",   104, PCD, 32'h84);
        chk("resume_pcf",   104, PCF, 32'h88);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_fetch_stage
